// File: rtl/kb_event_arbiter.sv
// Round-robin arbiter sharing the keyboard event FIFO write port between N_SRC event sources.
// Define KB_EVARB_PRIO0_EN to give source 0 (key matrix) strict priority over the others.
module kb_event_arbiter #(
  parameter int N_SRC = 4,
  parameter int EV_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        reqValid,
  input  logic [N_SRC*EV_W-1:0]   reqCode,
  output logic [N_SRC-1:0]        reqAck,
  input  logic                    fifoFull,
  output logic                    fifoWrEn,
  output logic [EV_W-1:0]         fifoData,
  output logic [N_SRC-1:0]        ovf,
  input  logic                    ovfClr,
  output logic [N_SRC-1:0]        pending
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] slot_valid;
  logic [EV_W-1:0]  slot_code [N_SRC];
  logic [PTR_W-1:0] rr_ptr;

  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] grant_g;
  logic [PTR_W-1:0] rr_next;
  logic             grant_ok;
  logic             prio_hit;
  logic             rr_found;
  logic [N_SRC-1:0] grant_vec;
  logic [N_SRC-1:0] load_vec;
  logic [N_SRC-1:0] drop_vec;

  // First valid slot searching from rr_ptr upward, wrapping modulo N_SRC.
  always_comb begin : rr_search
    int idx;
    logic [PTR_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx  = (int'(rr_ptr) + k) % N_SRC;
      cand = PTR_W'(idx);
      if (!rr_found && slot_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef KB_EVARB_PRIO0_EN
  // Source 0 pre-empts the rotation and leaves rr_ptr untouched when it wins.
  assign prio_hit = slot_valid[0];
`else
  assign prio_hit = 1'b0;
`endif

  assign grant_g  = prio_hit ? '0 : rr_idx;
  assign grant_ok = (|slot_valid) & ~fifoFull;
  assign rr_next  = (grant_g == PTR_W'(N_SRC - 1)) ? '0 : grant_g + PTR_W'(1);

  always_comb begin : grant_decode
    grant_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant_vec[i] = grant_ok && (grant_g == PTR_W'(i));
    end
  end

  // A slot being drained on this edge can take a new event without loss.
  assign load_vec = reqValid & (~slot_valid | grant_vec);
  assign drop_vec = reqValid & slot_valid & ~grant_vec;

  assign fifoWrEn = grant_ok;
  assign fifoData = grant_ok ? slot_code[grant_g] : '0;
  assign pending  = slot_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      ovf        <= '0;
      reqAck     <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        slot_code[i] <= '0;
      end
    end else begin
      reqAck <= load_vec;
      ovf    <= (ovfClr ? '0 : ovf) | drop_vec;
      if (grant_ok && !prio_hit) begin
        rr_ptr <= rr_next;
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (load_vec[i]) begin
          slot_valid[i] <= 1'b1;
          slot_code[i]  <= reqCode[i*EV_W +: EV_W];
        end else if (grant_vec[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kb_event_arbiter.sv
// Bench for kb_event_arbiter: directed vectors, a queue-free slot model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_kb_event_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [N*W-1:0] reqCode;
  logic [N-1:0]   reqAck;
  logic           fifoFull;
  logic           fifoWrEn;
  logic [W-1:0]   fifoData;
  logic [N-1:0]   ovf;
  logic           ovfClr;
  logic [N-1:0]   pending;

  kb_event_arbiter #(.N_SRC(N), .EV_W(W)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqCode(reqCode), .reqAck(reqAck),
    .fifoFull(fifoFull), .fifoWrEn(fifoWrEn), .fifoData(fifoData), .ovf(ovf),
    .ovfClr(ovfClr), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one buffered event per source, drained by rotating preference.
  bit         m_init = 1'b0;
  bit         m_valid [N];
  logic [7:0] m_code  [N];
  bit         m_ovf   [N];
  bit         m_ack   [N];
  int         m_rr;

  function automatic int model_grant();
    if (fifoFull) return -1;
`ifdef KB_EVARB_PRIO0_EN
    if (m_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (m_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] pack(input bit v [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_rr   = 0;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_code[i] = 8'h00; m_ovf[i] = 0; m_ack[i] = 0;
      end
    end else if (m_init) begin
      int g;
      g = model_grant();
      if (g >= 0) begin
        m_valid[g] = 0;
`ifdef KB_EVARB_PRIO0_EN
        if (g != 0) m_rr = (g + 1) % N;
`else
        m_rr = (g + 1) % N;
`endif
      end
      if (ovfClr) for (int i = 0; i < N; i++) m_ovf[i] = 0;
      for (int i = 0; i < N; i++) begin
        m_ack[i] = 0;
        if (reqValid[i]) begin
          if (!m_valid[i]) begin
            m_valid[i] = 1;
            m_code[i]  = reqCode[i*W +: W];
            m_ack[i]   = 1;
          end else begin
            m_ovf[i] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      int g;
      g = model_grant();
      check("model_wr_en", 32'(fifoWrEn), 32'(g >= 0));
      check("model_data", 32'(fifoData), (g >= 0) ? 32'(m_code[g]) : 32'h0);
      check("model_ack", 32'(reqAck), 32'(pack(m_ack)));
      check("model_ovf", 32'(ovf), 32'(pack(m_ovf)));
      check("model_pending", 32'(pending), 32'(pack(m_valid)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_code(input int src, input logic [7:0] code);
    reqCode[src*W +: W] = code;
  endtask

  initial begin
    rst = 1'b1; reqValid = 4'b1111; reqCode = 32'hDEAD_BEEF; fifoFull = 1'b0; ovfClr = 1'b0;

    // reset with requests asserted
    tick(); tick();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_wr_en", 32'(fifoWrEn), 32'h0);
    check("rst_ack", 32'(reqAck), 32'h0);
    check("rst_data", 32'(fifoData), 32'h0);
    rst = 1'b0; reqValid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_no_write", 32'(fifoWrEn), 32'h0);
    end

    // single event on source 2
    reqValid = 4'b0100; set_code(2, 8'h5A);
    tick(); reqValid = '0;
    check("single_ack", 32'(reqAck), 32'h4);
    check("single_wr_en", 32'(fifoWrEn), 32'h1);
    check("single_data", 32'(fifoData), 32'h5A);
    tick();
    check("single_drained", 32'(fifoWrEn), 32'h0);

    // source 3 event brings the pointer back to 0
    reqValid = 4'b1000; set_code(3, 8'h99);
    tick(); reqValid = '0;
    check("realign_data", 32'(fifoData), 32'h99);
    tick();

    // four-way contention from pointer 0
    reqValid = 4'b1111;
    set_code(0, 8'h10); set_code(1, 8'h21); set_code(2, 8'h32); set_code(3, 8'h43);
    tick(); reqValid = '0;
    check("cont_ack", 32'(reqAck), 32'hF);
    check("cont_w0", 32'(fifoData), 32'h10);
    tick(); check("cont_w1", 32'(fifoData), 32'h21);
    tick(); check("cont_w2", 32'(fifoData), 32'h32);
    tick(); check("cont_w3", 32'(fifoData), 32'h43);
    tick(); check("cont_idle", 32'(fifoWrEn), 32'h0);

    // back-pressure, drop, and set-wins-over-clear
    fifoFull = 1'b1;
    reqValid = 4'b0010; set_code(1, 8'hA1);
    tick(); reqValid = '0;
    check("bp_ack", 32'(reqAck), 32'h2);
    check("bp_no_write", 32'(fifoWrEn), 32'h0);
    reqValid = 4'b0010; set_code(1, 8'hA2);
    tick(); reqValid = '0;
    check("bp_drop_ack", 32'(reqAck), 32'h0);
    check("bp_drop_ovf", 32'(ovf), 32'h2);
    ovfClr = 1'b1; reqValid = 4'b0010; set_code(1, 8'hA3);
    tick(); ovfClr = 1'b0; reqValid = '0;
    check("bp_set_wins", 32'(ovf), 32'h2);
    tick();
    check("bp_hold", 32'(pending), 32'h2);
    check("bp_hold_wr", 32'(fifoWrEn), 32'h0);
    fifoFull = 1'b0;
    #2;
    check("bp_release_wr", 32'(fifoWrEn), 32'h1);
    check("bp_release_data", 32'(fifoData), 32'hA1);
    tick();
    check("bp_one_write", 32'(fifoWrEn), 32'h0);
    ovfClr = 1'b1;
    tick(); ovfClr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 32'h0);

    // grant and capture on the same edge for source 3
    reqValid = 4'b1000; set_code(3, 8'h77);
    tick();
    check("sim_first", 32'(fifoData), 32'h77);
    set_code(3, 8'h78);
    tick(); reqValid = '0;
    check("sim_second", 32'(fifoData), 32'h78);
    check("sim_ack", 32'(reqAck), 32'h8);
    check("sim_no_ovf", 32'(ovf), 32'h0);
    tick();
    check("sim_idle", 32'(fifoWrEn), 32'h0);

    // pointer to 2 via a source 1 grant, then sources 0,1,2 pending together
    reqValid = 4'b0010; set_code(1, 8'hB1);
    tick(); reqValid = '0;
    tick();
    fifoFull = 1'b1; reqValid = 4'b0111;
    set_code(0, 8'hC0); set_code(1, 8'hC1); set_code(2, 8'hC2);
    tick(); reqValid = '0; fifoFull = 1'b0;
    #2;
`ifdef KB_EVARB_PRIO0_EN
    check("prio_w0", 32'(fifoData), 32'hC0);
    tick(); check("prio_w1", 32'(fifoData), 32'hC2);
`else
    check("rr_w0", 32'(fifoData), 32'hC2);
    tick(); check("rr_w1", 32'(fifoData), 32'hC0);
`endif
    tick(); check("order_w2", 32'(fifoData), 32'hC1);
    tick(); check("order_idle", 32'(fifoWrEn), 32'h0);

    // mixed traffic, checked only by the model
    for (int c = 0; c < 80; c++) begin
      reqValid = 4'($urandom_range(0, 15));
      reqCode  = $urandom;
      fifoFull = ($urandom_range(0, 3) == 0);
      ovfClr   = ($urandom_range(0, 9) == 0);
      tick();
    end

    // reset with events in flight
    fifoFull = 1'b1; reqValid = 4'b1111;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; reqValid = '0; fifoFull = 1'b0; ovfClr = 1'b0;
    check("rst2_pending", 32'(pending), 32'h0);
    check("rst2_ovf", 32'(ovf), 32'h0);
    check("rst2_wr_en", 32'(fifoWrEn), 32'h0);
    tick();
    check("rst2_no_write", 32'(fifoWrEn), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kb_event_arbiter.md
Name: kb_event_arbiter

Overview:
- Shares the single write port of the keyboard event FIFO between independent event sources: key matrix scanner, encoder decoders, joystick.
- Each source posts 8-bit event codes. The arbiter buffers one pending event per source and drains them round-robin into the FIFO, honouring FIFO full.
- Runs on the keyboard scan clock domain, between the event producers and the FIFO that the SPI reply path reads.

Parameters:
- N_SRC, 4, number of event sources (2..8).
- EV_W, 8, event code width; matches the FIFO event width.

Ports:
- clk  in  1  scan clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  N_SRC  per-source event strobe, 1-cycle pulse per event.
- reqCode  in  N_SRC*EV_W  per-source event code; source i at bits [i*EV_W +: EV_W].
- reqAck  out  N_SRC  1-cycle pulse: the event was accepted into the source slot.
- fifoFull  in  1  FIFO full flag, same clock domain.
- fifoWrEn  out  1  FIFO write strobe.
- fifoData  out  EV_W  FIFO write data.
- ovf  out  N_SRC  sticky per-source drop flags.
- ovfClr  in  1  clears all ovf bits.
- pending  out  N_SRC  slot-valid vector, for status readback.

Behaviour:
- State:
  - slotValid[N_SRC]
  - slotCode[N_SRC][EV_W]
  - rrPtr (clog2 N_SRC bits)
  - ovf[N_SRC]
  - reqAck register
- Reset, with rst high at an edge:
  - slotValid=0, slotCode=0, rrPtr=0, ovf=0, reqAck=0.
  - fifoWrEn=0 and fifoData=0 in the following cycle.
  - Any event in flight is discarded.
  - reqValid is ignored during a reset cycle: no capture, no ovf.
- Grant is combinational from registered state only. No combinational path from reqValid or reqCode to the fifo outputs.
  - grantOk = |slotValid & !fifoFull.
  - g = first i with slotValid[i], searching rrPtr, rrPtr+1, ... wrapping modulo N_SRC.
  - fifoWrEn = grantOk; fifoData = grantOk ? slotCode[g] : 0.
- On an edge with grantOk:
  - slotValid[g] is cleared.
  - rrPtr becomes (g+1) mod N_SRC. At g = N_SRC-1 it wraps to 0.
  - Without grantOk, rrPtr holds.
- Capture, per source i, on an edge with reqValid[i]:
  - If the slot is empty, or is being granted on this same edge: slotCode[i] is loaded with the new code, slotValid[i] is set, and reqAck[i] is 1 in the next cycle. The new event is not lost.
  - If the slot is occupied and not granted on this edge: the event is dropped, slotCode is unchanged, reqAck[i] stays 0, and ovf[i] is set.
- Latency: reqValid at edge k puts the event on fifoWrEn in cycle k+1 at the earliest, if no contention and FIFO not full.
- Throughput: one FIFO write per cycle while any slot is valid and the FIFO is not full.
- fifoFull held high: no writes, slots hold, rrPtr holds. Writing resumes in the first cycle fifoFull is low.
- ovfClr at an edge clears all ovf bits. If a drop occurs on the same edge, that source's bit is set (set wins).
- pending = slotValid.
- N_SRC=1 degenerates to a single-slot buffer; rrPtr stays 0.

Optional Feature:
- Macro: KB_EVARB_PRIO0_EN.
- Defined:
  - Source 0 (key matrix) has strict priority: if slotValid[0] and the FIFO is not full, g=0 regardless of rrPtr, and rrPtr is not updated on that grant.
  - Sources 1..N_SRC-1 stay round-robin among themselves.
- Undefined: pure round-robin over all sources as above.
- Port list is identical in both builds.

Test Plan:
- Reset: drive rst for 2 cycles with reqValid=4'b1111 -> pending=0, ovf=0, fifoWrEn=0, reqAck=0; no FIFO write in the next 3 cycles.
- Single event: reqValid[2] pulse with code 8'h5A, fifoFull=0 -> reqAck[2]=1 and fifoWrEn=1 with fifoData=8'h5A one cycle later; rrPtr=3 afterwards.
- Contention (build without macro): all four sources pulse together with codes 8'h10, 8'h21, 8'h32, 8'h43, rrPtr=0 -> four consecutive writes in order 10, 21, 32, 43; rrPtr wraps back to 0.
- Full back-pressure: fifoFull=1, post 8'hA1 on source 1 then a second 8'hA2 on source 1 -> first gets reqAck, second dropped with ovf[1]=1; release fifoFull -> exactly one write 8'hA1. ovfClr pulse -> ovf=0.
- Simultaneous grant and capture: slot 3 holds 8'h77 and is granted on the same edge reqValid[3] brings 8'h78 -> write 8'h77, then 8'h78 next cycle; reqAck[3]=1, ovf[3]=0.
- KB_EVARB_PRIO0_EN: rrPtr=1, sources 1 and 0 both pending -> source 0 is written first, then source 1; rrPtr stays 1 until source 1 is granted.
